// File: rtl/sad_pkg.sv
// Shared constants and state type for the SAD best-match search controller.
package sad_pkg;

    localparam int SAD_W   = 10;
    localparam int SAD_MAX = 1020;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sad_bm_state_t;

endpackage

// File: rtl/sad_min_reg.sv
// Running-minimum register: remembers the smallest SAD seen so far and its candidate index.
module sad_min_reg #(
    parameter int ADDR_W = 2,
    parameter int SAD_W  = sad_pkg::SAD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              first,
    input  logic [SAD_W-1:0]  value,
    input  logic [ADDR_W-1:0] index,
    output logic [SAD_W-1:0]  best_value,
    output logic [ADDR_W-1:0] best_index
);

    // Strict less-than keeps the earliest (lowest) index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_value <= '0;
            best_index <= '0;
        end else if (clear) begin
            best_value <= '1;
            best_index <= '0;
        end else if (load && (first || (value < best_value))) begin
            best_value <= value;
            best_index <= index;
        end
    end

endmodule

// File: rtl/sad_best_match.sv
// Block-matching search controller: sweeps candidate addresses into the SAD unit and
// reports the candidate with the smallest SAD through a start/done handshake.
module sad_best_match #(
    parameter int ADDR_W     = 2,
    parameter int NUM_CAND   = 4,
    parameter int SAD_W      = sad_pkg::SAD_W,
    parameter int SAD_LAT    = 1,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] address,
    input  logic [SAD_W-1:0]  sad,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] best_addr,
    output logic [SAD_W-1:0]  best_sad
);

    import sad_pkg::*;

    localparam int                WCNT_W    = (SAD_LAT > 0) ? $clog2(SAD_LAT + 1) : 1;
    localparam logic [WCNT_W-1:0] LAT       = WCNT_W'(SAD_LAT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CAND - 1);

    sad_bm_state_t     state;
    logic [WCNT_W-1:0] wcnt;
    logic              start_search;
    logic              sample;
    logic              last_sample;

    assign start_search = (state == IDLE) && start;
    assign sample       = (state == RUN) && (wcnt == LAT);
    assign last_sample  = (address == LAST_ADDR) || (EARLY_EXIT && (sad == '0));

    // The wait counter lets the SAD unit settle SAD_LAT cycles on each address before sampling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            address <= '0;
            wcnt    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        address <= '0;
                        wcnt    <= '0;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (!sample) begin
                        wcnt <= wcnt + 1'b1;
                    end else if (last_sample) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        address <= address + 1'b1;
                        wcnt    <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sad_min_reg #(
        .ADDR_W (ADDR_W),
        .SAD_W  (SAD_W)
    ) u_min (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_search),
        .load       (sample),
        .first      (address == '0),
        .value      (sad),
        .index      (address),
        .best_value (best_sad),
        .best_index (best_addr)
    );

endmodule

// File: doc/sad_best_match.md
# sad_best_match

Search controller for block-matching motion estimation. It drives the `address` input of the SAD memory/compute stage (`SAD_reg_mem`, 2-bit address, 10-bit `sad`) through every candidate block and consumes the returned SAD values. It keeps the minimum SAD and reports the winning candidate address with a start/done handshake. It is the stage that both feeds and consumes the SAD unit.

## Interface
Parameters:
- `ADDR_W`, 2: width of the candidate address.
- `NUM_CAND`, 4: number of candidates swept, 1..2^ADDR_W, addresses 0..NUM_CAND-1.
- `SAD_W`, 10: SAD width. 4 × 8-bit absolute differences, max 1020.
- `SAD_LAT`, 1: cycles from an `address` change until `sad` is valid, ≥0.
- `EARLY_EXIT`, 1: when 1, the search ends as soon as a SAD of 0 is sampled.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a search; sampled only in IDLE.
- `address`  out  ADDR_W  candidate address to the SAD unit (registered).
- `sad`  in  SAD_W  SAD of the block at `address`, valid SAD_LAT cycles after `address` changes.
- `busy`  out  1  high while the state is RUN.
- `done`  out  1  one-cycle pulse; the result is valid.
- `best_addr`  out  ADDR_W  address of the minimum SAD.
- `best_sad`  out  SAD_W  minimum SAD value.

## Operation
- States:
  - IDLE → RUN when `start`=1.
  - RUN → DONE after the last sample (last candidate, or zero SAD with EARLY_EXIT).
  - DONE → IDLE unconditionally.
- On IDLE→RUN:
  - `address`←0, wait counter `wcnt`←0.
  - `best_sad`←all ones, `best_addr`←0 (internal running values).
- Each RUN cycle:
  - If `wcnt`≠SAD_LAT: `wcnt`++ and `address` is held.
  - If `wcnt`=SAD_LAT, sample `sad`:
    - The first candidate is always loaded.
    - Later candidates replace the best only if `sad` < current best (strict compare). On a tie the lowest address wins.
    - If the sample is the last candidate, or EARLY_EXIT=1 and `sad`=0: go to DONE.
    - Otherwise `address`++ and `wcnt`←0.
- DONE: `done`=1 for exactly one cycle. `best_addr`/`best_sad` hold the final result and keep it until the next IDLE→RUN transition.
- `start` while RUN or DONE is ignored; it is not queued.
- Compare is unsigned on the full SAD_W width. There is no arithmetic beyond the comparison and the counters.

## Timing
- Reset values: state IDLE, `address`=0, `busy`=0, `done`=0, `best_addr`=0, `best_sad`=0, `wcnt`=0.
- Reset asserted mid-search aborts the search: the reset values above apply on the next edge, and no `done` is produced.
- `start` high at edge T → `busy`=1 and `address`=0 from T+1.
- Each candidate occupies SAD_LAT+1 RUN cycles.
- Full sweep: `done` is high in cycle T+1+NUM_CAND·(SAD_LAT+1); `busy` is low in that cycle.
- Earliest next `start` accepted: the cycle after `done`.
- With SAD_LAT=0, `sad` is treated as combinational from `address`: one candidate per cycle.

## Structure
- Shared package `sad_pkg`:
  - `SAD_W` and `SAD_MAX` (1020) constants.
  - State typedef `sad_bm_state_t` {IDLE, RUN, DONE}.
- Single module. The running-minimum register plus comparator may be split into sub-module `sad_min_reg` (inputs: load, first, value, index; outputs: best value/index). The FSM, address counter and wait counter stay in `sad_best_match`.

## Test plan
- Bench wired to `SAD_reg_mem` contents {4,5,0,1020}, EARLY_EXIT=0, SAD_LAT=1, start pulse at T:
  - `done` at T+9 with `best_addr`=2, `best_sad`=0.
  - `address` sequence is 0,0,1,1,2,2,3,3.
- Same memory, EARLY_EXIT=1: `done` at T+7, `best_addr`=2, `best_sad`=0, and `address` never reaches 3.
- Stub returning {7,3,3,9}: `best_addr`=1, `best_sad`=3 (tie resolves to the lower address).
- Stub returning all 1020: `best_addr`=0, `best_sad`=1020 (first candidate loaded despite equality).
- `rst` raised in the cycle after the 2nd sample:
  - Next cycle all outputs are 0 and `busy`=0.
  - No `done` pulse.
  - A new `start` then completes normally.
- `start` held high continuously: searches run back-to-back, with one IDLE cycle between `done` and the next `busy`, and `done` pulses each time.
